// File: rtl/cpu_core_seq.sv
// cpu_core_seq: minimal accumulator CPU with a sequential FETCH/EXEC/MEM/HALT
// control path and a single shared memory port using a req/ack handshake.
//
// Ports
//   clk        system clock, all state updates on the rising edge
//   reset      synchronous, active-high reset
//   mem_req    memory request valid (FETCH and MEM states only)
//   mem_we     1 = write, 0 = read, valid while mem_req=1
//   mem_addr   request address (pc in FETCH, instruction operand in MEM)
//   mem_wdata  write data, always the accumulator
//   mem_rdata  read data, valid when mem_ack=1
//   mem_ack    completes the current request on the same edge
//   acc        accumulator
//   pc         program counter
//   zero       last ADD/SUB result was zero
//   carry      ADD carry-out or SUB borrow
//   halted     core is in HALT
module cpu_core_seq #(
   parameter int unsigned DW = 8,
   parameter int unsigned AW = 4
) (
   input  logic          clk,
   input  logic          reset,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ack,
   output logic [DW-1:0] acc,
   output logic [AW-1:0] pc,
   output logic          zero,
   output logic          carry,
   output logic          halted
);

   localparam int unsigned OPW = 4;

   localparam logic [OPW-1:0] OP_LDA = 4'b1000;
   localparam logic [OPW-1:0] OP_LDB = 4'b0100;
   localparam logic [OPW-1:0] OP_ADD = 4'b0010;
   localparam logic [OPW-1:0] OP_SUB = 4'b0001;
   localparam logic [OPW-1:0] OP_JMP = 4'b1001;
   localparam logic [OPW-1:0] OP_WRT = 4'b1010;
   localparam logic [OPW-1:0] OP_JZ  = 4'b1011;
   localparam logic [OPW-1:0] OP_HLT = 4'b1111;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_EXEC  = 2'd1,
      S_MEM   = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   state_t          state_q;
   logic [OPW-1:0]  op_q;     // IR opcode field
   logic [AW-1:0]   opnd_q;   // IR operand field; the unused middle bits are not kept
   logic [AW-1:0]   pc_q;
   logic [DW-1:0]   a_q;
   logic [DW-1:0]   b_q;
   logic [DW-1:0]   acc_q;
   logic            zero_q;
   logic            carry_q;

   // Both ALU results in DW+1 bits; the top bit is ADD carry-out / SUB borrow.
   logic [DW:0]     add_d;
   logic [DW:0]     sub_d;

   assign add_d = {1'b0, a_q} + {1'b0, b_q};
   assign sub_d = {1'b0, a_q} - {1'b0, b_q};

   // Memory port is a pure decode of registered state; reset forces it idle
   // so an in-flight request is dropped in the reset cycle itself.
   assign mem_req   = !reset && ((state_q == S_FETCH) || (state_q == S_MEM));
   assign mem_we    = !reset && (state_q == S_MEM) && (op_q == OP_WRT);
   assign mem_addr  = reset ? '0 : ((state_q == S_MEM) ? opnd_q : pc_q);
   assign mem_wdata = acc_q;

   assign acc    = acc_q;
   assign pc     = pc_q;
   assign zero   = zero_q;
   assign carry  = carry_q;
   assign halted = !reset && (state_q == S_HALT);

   // Control FSM and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         op_q    <= '0;
         opnd_q  <= '0;
         pc_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
      end else begin
         case (state_q)
            S_FETCH: begin
               if (mem_ack) begin
                  op_q    <= mem_rdata[DW-1 -: OPW];
                  opnd_q  <= mem_rdata[AW-1:0];
                  pc_q    <= pc_q + AW'(1);
                  state_q <= S_EXEC;
               end
            end
            S_EXEC: begin
               state_q <= S_FETCH;
               case (op_q)
                  OP_LDA, OP_LDB, OP_WRT: state_q <= S_MEM;
                  OP_HLT:                 state_q <= S_HALT;
                  OP_ADD: begin
                     acc_q   <= add_d[DW-1:0];
                     carry_q <= add_d[DW];
                     zero_q  <= (add_d[DW-1:0] == '0);
                  end
                  OP_SUB: begin
                     acc_q   <= sub_d[DW-1:0];
                     carry_q <= sub_d[DW];
                     zero_q  <= (sub_d[DW-1:0] == '0);
                  end
                  OP_JMP: pc_q <= opnd_q;
                  OP_JZ: begin
                     if (zero_q) begin
                        pc_q <= opnd_q;
                     end
                  end
                  default: ;
               endcase
            end
            S_MEM: begin
               // WRT needs no datapath action: the write completes on the ack.
               if (mem_ack) begin
                  if (op_q == OP_LDA) begin
                     a_q <= mem_rdata;
                  end
                  if (op_q == OP_LDB) begin
                     b_q <= mem_rdata;
                  end
                  state_q <= S_FETCH;
               end
            end
            default: ; // S_HALT: frozen until reset
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_core_seq.sv
// Self-checking bench for cpu_core_seq (DW=8, AW=4).
module tb_cpu_core_seq;

   logic       clk;
   logic       reset;
   logic       mem_req;
   logic       mem_we;
   logic [3:0] mem_addr;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;
   logic       mem_ack;
   logic [7:0] acc;
   logic [3:0] pc;
   logic       zero;
   logic       carry;
   logic       halted;

   int n_checks;
   int n_fail;

   logic [7:0]  mem [16];
   bit          resp_en;
   int          rd_q[$];   // addresses of acked reads, in order
   logic [11:0] wr_q[$];   // {addr, data} of acked writes, in order

   cpu_core_seq #(.DW(8), .AW(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .acc       (acc),
      .pc        (pc),
      .zero      (zero),
      .carry     (carry),
      .halted    (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Zero-wait memory responder; logs every completed transfer.
   always @(negedge clk) begin
      #1;
      if (resp_en) begin
         if (mem_req && !reset) begin
            mem_ack = 1'b1;
            if (mem_we) begin
               wr_q.push_back({mem_addr, mem_wdata});
            end else begin
               mem_rdata = mem[mem_addr];
               rd_q.push_back(int'(mem_addr));
            end
         end else begin
            mem_ack = 1'b0;
         end
      end
   end

   task automatic do_reset(input bit en);
      reset   = 1'b1;
      resp_en = 1'b0;
      mem_ack = 1'b0;
      repeat (2) @(negedge clk);
      rd_q.delete();
      wr_q.delete();
      resp_en = en;
      reset   = 1'b0;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      resp_en = 1'b0;
      mem_ack = 1'b1;
      mem_rdata = 8'hF0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({mem_req, mem_we, halted} !== 3'b000) begin
         n_fail++; $display("FAIL reset_ctrl: got %b expected 000", {mem_req, mem_we, halted});
      end
      n_checks++;
      if ({acc, pc, zero, carry} !== 14'h0) begin
         n_fail++; $display("FAIL reset_regs: got acc=%h pc=%h z=%b c=%b expected zeros", acc, pc, zero, carry);
      end
      mem_ack = 1'b0;
      reset = 1'b0;
      #2;
      n_checks++;
      if ({mem_req, mem_we, mem_addr} !== 6'b10_0000) begin
         n_fail++; $display("FAIL reset_first_fetch: got req=%b we=%b addr=%h expected 1 0 0", mem_req, mem_we, mem_addr);
      end
   endtask

   task automatic test_program();
      int exp_rd[7] = '{0, 6, 1, 7, 2, 3, 4};
      logic [11:0] exp_wr[$];
      clear_mem();
      mem[0] = 8'h86; mem[1] = 8'h47; mem[2] = 8'h20; mem[3] = 8'hA8;
      mem[4] = 8'hF0; mem[6] = 8'h0E; mem[7] = 8'h0C;
      exp_wr.push_back({4'h8, 8'h1A});
      do_reset(1'b1);
      repeat (15) @(negedge clk);
      n_checks++;
      if ({halted, pc} !== {1'b1, 4'h5}) begin
         n_fail++; $display("FAIL prog_halt: got halted=%b pc=%h expected 1 5", halted, pc);
      end
      n_checks++;
      if ({acc, carry, zero} !== {8'h1A, 2'b00}) begin
         n_fail++; $display("FAIL prog_acc: got acc=%h c=%b z=%b expected 1a 0 0", acc, carry, zero);
      end
      n_checks++;
      if (mem_req !== 1'b0) begin
         n_fail++; $display("FAIL prog_halt_req: got %b expected 0", mem_req);
      end
      for (int i = 0; i < 7; i++) begin
         n_checks++;
         if (rd_q.size() == 0) begin
            n_fail++; $display("FAIL prog_read[%0d]: got none expected %0d", i, exp_rd[i]);
         end else begin
            int a = rd_q.pop_front();
            if (a !== exp_rd[i]) begin
               n_fail++; $display("FAIL prog_read[%0d]: got %0d expected %0d", i, a, exp_rd[i]);
            end
         end
      end
      n_checks++;
      if (rd_q.size() != 0 || wr_q.size() != exp_wr.size()) begin
         n_fail++; $display("FAIL prog_xfer_count: got reads_left=%0d writes=%0d expected 0 1", rd_q.size(), wr_q.size());
      end
      while (exp_wr.size() > 0 && wr_q.size() > 0) begin
         logic [11:0] e = exp_wr.pop_front();
         logic [11:0] o = wr_q.pop_front();
         n_checks++;
         if (o !== e) begin
            n_fail++; $display("FAIL prog_write: got %h expected %h", o, e);
         end
      end
   endtask

   task automatic test_arith(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] e_acc, input logic e_c, input logic e_z);
      clear_mem();
      mem[0] = 8'h8E; mem[1] = 8'h4F; mem[2] = op; mem[3] = 8'hF0;
      mem[14] = a; mem[15] = b;
      do_reset(1'b1);
      repeat (30) @(negedge clk);
      n_checks++;
      if ({halted, acc, carry, zero} !== {1'b1, e_acc, e_c, e_z}) begin
         n_fail++; $display("FAIL arith_%h: got h=%b acc=%h c=%b z=%b expected 1 %h %b %b",
                            op, halted, acc, carry, zero, e_acc, e_c, e_z);
      end
   endtask

   task automatic test_branch();
      int exp_t[7] = '{0, 14, 1, 15, 2, 3, 9};
      int exp_n[7] = '{0, 14, 1, 15, 2, 3, 4};
      int exp_j[3] = '{0, 15, 0};
      for (int k = 0; k < 2; k++) begin
         clear_mem();
         mem[0] = 8'h8E; mem[1] = 8'h4F; mem[2] = 8'h20; mem[3] = 8'hB9;
         mem[4] = 8'hF0; mem[9] = 8'hF0;
         mem[14] = (k == 0) ? 8'h00 : 8'h01;
         do_reset(1'b1);
         repeat (30) @(negedge clk);
         n_checks++;
         if ({halted, pc} !== {1'b1, (k == 0) ? 4'hA : 4'h5}) begin
            n_fail++; $display("FAIL jz_%0d_pc: got h=%b pc=%h", k, halted, pc);
         end
         for (int i = 0; i < 7; i++) begin
            int e = (k == 0) ? exp_t[i] : exp_n[i];
            n_checks++;
            if (rd_q.size() == 0) begin
               n_fail++; $display("FAIL jz_%0d_read[%0d]: got none expected %0d", k, i, e);
            end else begin
               int a = rd_q.pop_front();
               if (a !== e) begin
                  n_fail++; $display("FAIL jz_%0d_read[%0d]: got %0d expected %0d", k, i, a, e);
               end
            end
         end
      end
      // JMP 15, NOP at 15, pc wraps to 0
      clear_mem();
      mem[0] = 8'h9F;
      do_reset(1'b1);
      repeat (6) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (rd_q.size() == 0) begin
            n_fail++; $display("FAIL jmp_read[%0d]: got none expected %0d", i, exp_j[i]);
         end else begin
            int a = rd_q.pop_front();
            if (a !== exp_j[i]) begin
               n_fail++; $display("FAIL jmp_read[%0d]: got %0d expected %0d", i, a, exp_j[i]);
            end
         end
      end
   endtask

   task automatic test_wait();
      do_reset(1'b0);
      mem_ack = 1'b1; mem_rdata = 8'h86;          // fetch LDA 6
      @(negedge clk);
      n_checks++;
      if (mem_req !== 1'b0) begin
         n_fail++; $display("FAIL wait_exec_req: got %b expected 0", mem_req);
      end
      mem_ack = 1'b0; mem_rdata = 8'h55;
      for (int w = 0; w < 4; w++) begin
         @(negedge clk);
         n_checks++;
         if ({mem_req, mem_we, mem_addr} !== {2'b10, 4'h6}) begin
            n_fail++; $display("FAIL wait_hold[%0d]: got req=%b we=%b addr=%h expected 1 0 6", w, mem_req, mem_we, mem_addr);
         end
         mem_ack   = (w == 3);
         mem_rdata = (w == 3) ? 8'h33 : 8'h55;
      end
      @(negedge clk);                              // cycle 7: next fetch
      n_checks++;
      if ({mem_req, mem_we, mem_addr} !== {2'b10, 4'h1}) begin
         n_fail++; $display("FAIL wait_latency: got req=%b we=%b addr=%h expected 1 0 1", mem_req, mem_we, mem_addr);
      end
      mem_ack = 1'b1; mem_rdata = 8'h20;          // ADD, B=0
      @(negedge clk);
      mem_ack = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({acc, carry, zero, pc} !== {8'h33, 2'b00, 4'h2}) begin
         n_fail++; $display("FAIL wait_load: got acc=%h c=%b z=%b pc=%h expected 33 0 0 2", acc, carry, zero, pc);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] fs_ack [7] = '{8'h86, 8'h00, 8'h11, 8'h20, 8'h00, 8'hA8, 8'h00};
      bit         fs_v   [7] = '{1, 0, 1, 1, 0, 1, 0};
      do_reset(1'b0);
      for (int i = 0; i < 7; i++) begin
         mem_ack = fs_v[i]; mem_rdata = fs_ack[i];
         @(negedge clk);
      end
      n_checks++;
      if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 4'h8, 8'h11}) begin
         n_fail++; $display("FAIL rmid_wrt: got req=%b we=%b addr=%h wd=%h expected 1 1 8 11", mem_req, mem_we, mem_addr, mem_wdata);
      end
      reset = 1'b1; mem_ack = 1'b1;
      #1;
      n_checks++;
      if ({mem_req, mem_we} !== 2'b00) begin
         n_fail++; $display("FAIL rmid_nowrite: got req=%b we=%b expected 0 0", mem_req, mem_we);
      end
      @(negedge clk);
      n_checks++;
      if ({acc, pc, zero, carry, halted, mem_req, mem_we, mem_addr, mem_wdata} !== 31'h0) begin
         n_fail++; $display("FAIL rmid_zero: got acc=%h pc=%h z=%b c=%b h=%b req=%b we=%b addr=%h wd=%h",
                            acc, pc, zero, carry, halted, mem_req, mem_we, mem_addr, mem_wdata);
      end
      reset = 1'b0; mem_ack = 1'b0;
      #1;
      n_checks++;
      if ({mem_req, mem_addr} !== 5'b1_0000) begin
         n_fail++; $display("FAIL rmid_restart: got req=%b addr=%h expected 1 0", mem_req, mem_addr);
      end
   endtask

   task automatic test_spurious();
      do_reset(1'b0);
      mem_ack = 1'b1; mem_rdata = 8'h00;          // fetch NOP
      @(negedge clk);
      mem_ack = 1'b1; mem_rdata = 8'hF0;          // ack with no request
      @(negedge clk);
      n_checks++;
      if ({mem_req, mem_addr, pc, halted} !== {1'b1, 4'h1, 4'h1, 1'b0}) begin
         n_fail++; $display("FAIL spur_exec: got req=%b addr=%h pc=%h h=%b expected 1 1 1 0", mem_req, mem_addr, pc, halted);
      end
      mem_ack = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({mem_req, mem_addr, pc} !== {1'b1, 4'h1, 4'h1}) begin
         n_fail++; $display("FAIL spur_fetch_wait: got req=%b addr=%h pc=%h expected 1 1 1", mem_req, mem_addr, pc);
      end
      mem_ack = 1'b1; mem_rdata = 8'hF0;          // fetch HLT
      @(negedge clk);
      mem_ack = 1'b0;
      @(negedge clk);
      mem_ack = 1'b1; mem_rdata = 8'h86;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if ({halted, mem_req, pc, acc} !== {2'b10, 4'h2, 8'h00}) begin
            n_fail++; $display("FAIL spur_halt[%0d]: got h=%b req=%b pc=%h acc=%h expected 1 0 2 00", i, halted, mem_req, pc, acc);
         end
         @(negedge clk);
      end
      mem_ack = 1'b0;
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      reset     = 1'b1;
      resp_en   = 1'b0;
      mem_ack   = 1'b0;
      mem_rdata = 8'h00;
      clear_mem();
      test_reset();
      test_program();
      test_arith(8'h20, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1);
      test_arith(8'h10, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
      test_branch();
      test_wait();
      test_reset_mid();
      test_spurious();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
